// File: rtl/boot_loader.sv
// Byte-stream program loader: decodes write/run/halt frames from a valid/ready
// byte source, writes little-endian words into IMEM or DMEM, and holds the core
// in reset until a run command arrives.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   in_valid/in_data      incoming byte stream
//   in_ready              byte accept (always 1 after reset)
//   imem_we/addr/wdata    IMEM word write port (one-cycle strobe)
//   dmem_we/addr/wdata    DMEM word write port (one-cycle strobe)
//   core_reset            processor reset request, low only in RUN
//   busy                  write frame in progress
//   err                   sticky protocol / range error
//   words_written         saturating count of words written
module boot_loader #(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned DMEM_WORDS = 256,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic              core_reset,
  output logic              busy,
  output logic              err,
  output logic [15:0]       words_written
);

  localparam logic [7:0]  CMD_IMEM = 8'h01;
  localparam logic [7:0]  CMD_DMEM = 8'h02;
  localparam logic [7:0]  CMD_RUN  = 8'h03;
  localparam logic [7:0]  CMD_HALT = 8'h04;
  localparam logic [16:0] IMEM_LIM = 17'(IMEM_WORDS);
  localparam logic [16:0] DMEM_LIM = 17'(DMEM_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_LO, S_ADDR_HI, S_CNT_LO, S_CNT_HI, S_DATA, S_RUN
  } state_t;

  state_t             state, state_n;
  logic               tgt_dmem, tgt_dmem_n;
  logic [15:0]        base, base_n;
  logic [15:0]        cnt, cnt_n;
  logic [15:0]        widx, widx_n;
  logic [1:0]         bidx, bidx_n;
  logic [31:0]        asm_q, asm_n;

  logic               in_ready_n;
  logic               imem_we_n, dmem_we_n;
  logic [ADDR_W-1:0]  imem_addr_n, dmem_addr_n;
  logic [31:0]        imem_wdata_n, dmem_wdata_n;
  logic               core_reset_n, busy_n, err_n;
  logic [15:0]        words_written_n;

  logic               xfer;
  logic [16:0]        sum;
  logic [31:0]        word;
  logic [15:0]        cnt_full;

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      tgt_dmem      <= 1'b0;
      base          <= '0;
      cnt           <= '0;
      widx          <= '0;
      bidx          <= '0;
      asm_q         <= '0;
      in_ready      <= 1'b0;
      imem_we       <= 1'b0;
      imem_addr     <= '0;
      imem_wdata    <= '0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      core_reset    <= 1'b1;
      busy          <= 1'b0;
      err           <= 1'b0;
      words_written <= '0;
    end else begin
      state         <= state_n;
      tgt_dmem      <= tgt_dmem_n;
      base          <= base_n;
      cnt           <= cnt_n;
      widx          <= widx_n;
      bidx          <= bidx_n;
      asm_q         <= asm_n;
      in_ready      <= in_ready_n;
      imem_we       <= imem_we_n;
      imem_addr     <= imem_addr_n;
      imem_wdata    <= imem_wdata_n;
      dmem_we       <= dmem_we_n;
      dmem_addr     <= dmem_addr_n;
      dmem_wdata    <= dmem_wdata_n;
      core_reset    <= core_reset_n;
      busy          <= busy_n;
      err           <= err_n;
      words_written <= words_written_n;
    end
  end

  // Frame decode, word assembly and next-output computation
  always_comb begin
    state_n         = state;
    tgt_dmem_n      = tgt_dmem;
    base_n          = base;
    cnt_n           = cnt;
    widx_n          = widx;
    bidx_n          = bidx;
    asm_n           = asm_q;
    in_ready_n      = 1'b1;
    imem_we_n       = 1'b0;
    imem_addr_n     = imem_addr;
    imem_wdata_n    = imem_wdata;
    dmem_we_n       = 1'b0;
    dmem_addr_n     = dmem_addr;
    dmem_wdata_n    = dmem_wdata;
    err_n           = err;
    words_written_n = words_written;

    xfer     = in_valid && in_ready;
    // 17-bit sum so an address past the top never wraps back into range
    sum      = {1'b0, base} + {1'b0, widx};
    // Bytes shift in from the top, so after four bytes byte 0 sits in [7:0]
    word     = {in_data, asm_q[31:8]};
    cnt_full = {in_data, cnt[7:0]};

    if (xfer) begin
      case (state)
        S_IDLE: begin
          if (in_data == CMD_IMEM || in_data == CMD_DMEM) begin
            tgt_dmem_n = (in_data == CMD_DMEM);
            state_n    = S_ADDR_LO;
          end else if (in_data == CMD_RUN) begin
            state_n = S_RUN;
          end else if (in_data != CMD_HALT) begin
            err_n = 1'b1;
          end
        end
        S_ADDR_LO: begin
          base_n  = {8'h00, in_data};
          state_n = S_ADDR_HI;
        end
        S_ADDR_HI: begin
          base_n  = {in_data, base[7:0]};
          state_n = S_CNT_LO;
        end
        S_CNT_LO: begin
          cnt_n   = {8'h00, in_data};
          state_n = S_CNT_HI;
        end
        S_CNT_HI: begin
          cnt_n  = cnt_full;
          widx_n = '0;
          bidx_n = '0;
          state_n = (cnt_full == 16'h0000) ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          asm_n  = word;
          bidx_n = bidx + 2'd1;
          if (bidx == 2'd3) begin
            // Out-of-range words are consumed but not written
            if (sum < (tgt_dmem ? DMEM_LIM : IMEM_LIM)) begin
              if (tgt_dmem) begin
                dmem_we_n    = 1'b1;
                dmem_addr_n  = sum[ADDR_W-1:0];
                dmem_wdata_n = word;
              end else begin
                imem_we_n    = 1'b1;
                imem_addr_n  = sum[ADDR_W-1:0];
                imem_wdata_n = word;
              end
              if (words_written != 16'hFFFF) words_written_n = words_written + 16'd1;
            end else begin
              err_n = 1'b1;
            end
            if (widx == cnt - 16'd1) state_n = S_IDLE;
            else                     widx_n  = widx + 16'd1;
          end
        end
        S_RUN: begin
          if (in_data == CMD_HALT) state_n = S_IDLE;
          else                     err_n   = 1'b1;
        end
        default: state_n = S_IDLE;
      endcase
    end

    core_reset_n = (state_n != S_RUN);
    busy_n       = (state_n != S_IDLE) && (state_n != S_RUN);
  end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Hardware program loader. It receives a byte stream over a valid/ready interface and fills IMEM and DMEM with little-endian words, then releases the processor from reset.
- Sits in the SoC between a host-side byte source (UART RX or debug FIFO) and the memory write ports.
- Holds the core in reset while loading. Replaces file preload of imem/dmem on silicon and FPGA.

Parameters:
- IMEM_WORDS, 256, IMEM depth in 32-bit words (1024 bytes).
- DMEM_WORDS, 256, DMEM depth in 32-bit words (1024 bytes).
- ADDR_W, 8, width of the word-address outputs; must satisfy 2^ADDR_W >= max(IMEM_WORDS, DMEM_WORDS).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  stream byte valid.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte; a transfer occurs when in_valid && in_ready at posedge clk.
- imem_we  output  1  IMEM write strobe, one-cycle pulse.
- imem_addr  output  ADDR_W  IMEM word address.
- imem_wdata  output  32  IMEM write data.
- dmem_we  output  1  DMEM write strobe, one-cycle pulse.
- dmem_addr  output  ADDR_W  DMEM word address.
- dmem_wdata  output  32  DMEM write data.
- core_reset  output  1  processor/SoC reset request, active-high.
- busy  output  1  a write frame is in progress (any state other than IDLE or RUN).
- err  output  1  sticky protocol error flag.
- words_written  output  16  count of words written since reset.

Behaviour:
- All outputs registered. Reset values:
  - core_reset=1, in_ready=0, all other outputs 0.
  - State=IDLE.
- in_ready=1 from the first cycle after reset and in every state (one byte per cycle, no backpressure).
- Frame format:
  - CMD byte: 0x01 = write IMEM, 0x02 = write DMEM, 0x03 = run, 0x04 = halt.
  - Write frames follow CMD with: ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, then 4*CNT data bytes. Each word is sent LSB first.
- States: IDLE, ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, DATA, RUN. Transitions occur only on accepted bytes.
- IDLE transitions:
  - 0x01/0x02: latch the target memory, go to ADDR_LO.
  - 0x03: go to RUN; core_reset=0 from the next cycle.
  - 0x04: no-op, stay IDLE.
  - Any other byte: err<=1, stay IDLE.
- ADDR_LO/ADDR_HI: build the 16-bit base word address. CNT_LO/CNT_HI: build the 16-bit word count.
- After CNT_HI:
  - CNT==0: return to IDLE, no writes.
  - Otherwise: go to DATA with byte index 0 and word index 0.
- DATA:
  - Bytes shift into a 32-bit assembly register; byte k of the word lands in bits [8k+7:8k].
  - On the 4th byte, the cycle after acceptance: the selected *_we=1 for exactly one cycle, with addr = (base + word index) truncated to ADDR_W and wdata = the assembled word.
  - words_written increments by 1 and saturates at 0xFFFF.
  - After the word-count-th word, return to IDLE.
- Out-of-range word: if the untruncated address (base + word index) >= the target's *_WORDS, suppress the strobe, set err<=1, and still consume the bytes. The frame continues normally.
- The base+index sum is 17-bit; no wrap-around into low addresses.
- RUN:
  - core_reset=0.
  - 0x04: go to IDLE; core_reset=1 the next cycle.
  - Any other byte: discarded, err<=1.
- core_reset is 1 in every state except RUN; it is never 0 while a write frame is active.
- The imem_* and dmem_* outputs are never asserted in the same cycle. Addr/wdata hold their last values when the strobe is 0.
- in_valid=0 mid-frame: hold state indefinitely; there is no timeout.
- reset asserted mid-frame: abort on the next edge. All reset values are reapplied and err is cleared; the partial word is never written.
- err is cleared only by reset.

Test Plan:
- Bytes 01 00 00 01 00 78 56 34 12 -> exactly one imem_we pulse with imem_addr=0x00, imem_wdata=0x12345678, the cycle after the 9th byte is accepted. words_written=1, core_reset stays 1, err=0.
- Bytes 02 10 00 03 00 followed by 12 data bytes (words 0xAAAAAAAA, 0x00000001, 0xDEADBEEF) -> three dmem_we pulses at dmem_addr 0x10, 0x11, 0x12 with matching data. No imem_we. busy=0 after the last pulse.
- Byte 03 -> core_reset falls to 0 one cycle after acceptance, state RUN. Then byte 04 -> core_reset=1 next cycle, state IDLE. Then byte 55 in IDLE -> err=1.
- Bytes 01 FE 00 03 00 followed by 12 data bytes (IMEM_WORDS=256) -> writes at 0xFE and 0xFF only; the third word is suppressed and err=1. words_written=2.
- Bytes 01 05 00 00 00 -> no writes, busy=0, return to IDLE. The following byte 03 is accepted as a command and core_reset falls.
- Reset pulsed after 2 data bytes of a frame -> no write strobe. All outputs return to reset values (core_reset=1, err=0, words_written=0). A new full frame then writes correctly.
